// File: rtl/fadc_spi_responder_if.sv
// fadc_spi_responder_if: SPI pins plus the local register read and write-observe port
interface fadc_spi_responder_if #(parameter int ADDR_WIDTH = 5);
  logic sclk;
  logic sdi;
  logic csn;
  logic sdo;
  logic sdo_oe;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0] reg_data;
  logic wr_strobe;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;
  modport slave (
    input sclk, sdi, csn, reg_addr,
    output sdo, sdo_oe, reg_data, wr_strobe, wr_addr, wr_data, busy
  );
  modport master (
    output sclk, sdi, csn, reg_addr,
    input sdo, sdo_oe, reg_data, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/fadc_spi_responder.sv
// fadc_spi_responder: oversampled SPI slave emulating the FADC configuration register file
module fadc_spi_responder #(
  parameter int ADDR_WIDTH = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  fadc_spi_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_q, sdi_q, csn_q, fill;
  logic sclk_d, armed, stream, oor;
  logic [14:0] sr;
  logic [3:0] bit_cnt;
  logic [1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0] rd_sr;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic sclk_s, sdi_s, csn_s, rise, fall;
  logic [15:0] instr;
  logic [7:0] rbyte, rd_next;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sdi_s = sdi_q[SYNC_STAGES-1];
  assign csn_s = csn_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign instr = {sr, sdi_s};
  assign rbyte = oor ? 8'h00 : mem[addr];
  assign rd_next = bit_cnt == 4'd0 ? rbyte : rd_sr;
  assign bus.reg_data = mem[bus.reg_addr];
  assign bus.busy = state != IDLE;
  // fill marks when the CSN synchroniser output reflects the pin rather than its reset value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      sdi_q <= '0;
      csn_q <= '1;
      fill <= '0;
      sclk_d <= 1'b0;
      armed <= 1'b0;
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      cnt <= '0;
      stream <= 1'b0;
      oor <= 1'b0;
      addr <= '0;
      rd_sr <= '0;
      bus.sdo <= 1'b0;
      bus.sdo_oe <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], bus.sdi};
      csn_q <= {csn_q[SYNC_STAGES-2:0], bus.csn};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d <= sclk_s;
      armed <= armed | (fill[SYNC_STAGES-1] & csn_s);
      bus.wr_strobe <= 1'b0;
      if (state != IDLE && csn_s) begin
        state <= IDLE;
        bus.sdo <= 1'b0;
        bus.sdo_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (armed && !csn_s) begin
            state <= INSTR;
            bit_cnt <= '0;
          end
          INSTR: if (rise) begin
            sr <= instr[14:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state <= instr[15] ? RDATA : WDATA;
              bus.sdo_oe <= instr[15];
              cnt <= instr[14:13];
              stream <= &instr[14:13];
              addr <= instr[ADDR_WIDTH-1:0];
              oor <= |(instr[12:0] >> ADDR_WIDTH);
            end
          end
          WDATA: if (rise) begin
            sr <= instr[14:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              addr <= addr + 1'b1;
              cnt <= cnt - 2'd1;
              if (!oor) begin
                mem[addr] <= instr[7:0];
                bus.wr_strobe <= 1'b1;
                bus.wr_addr <= addr;
                bus.wr_data <= instr[7:0];
              end
              if (!stream && cnt == 2'd0) state <= DONE;
            end
          end
          RDATA: if (fall) begin
            bus.sdo <= rd_next[7];
            rd_sr <= {rd_next[6:0], 1'b0};
          end else if (rise) begin
            bit_cnt <= bit_cnt == 4'd7 ? 4'd0 : bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              addr <= addr + 1'b1;
              cnt <= cnt - 2'd1;
              if (!stream && cnt == 2'd0) begin
                state <= DONE;
                bus.sdo <= 1'b0;
                bus.sdo_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fadc_spi_responder.sv
// tb_fadc_spi_responder: randomized SPI master checked against a byte-level register-file model
module tb_fadc_spi_responder;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem [DEPTH];
  logic [12:0] expq [$];
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];
  logic [7:0] d;
  always #5 clk = ~clk;
  fadc_spi_responder_if #(.ADDR_WIDTH(AW)) bus();
  fadc_spi_responder #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input logic b, output logic so, output logic oe);
    bus.sdi = b;
    wait_clk(4);
    so = bus.sdo;
    oe = bus.sdo_oe;
  endtask

  task automatic pulse();
    bus.sclk = 1'b1;
    wait_clk(4);
    bus.sclk = 1'b0;
  endtask

  task automatic peek(input int a, output logic [7:0] v);
    bus.reg_addr = AW'(a);
    @(posedge clk);
    #2;
    v = bus.reg_data;
  endtask

  // Expected behaviour is derived from the instruction word: byte count, wrap and range rules
  task automatic xfer(input logic [15:0] ins, input int nb, input int ab);
    logic rd, strm, oor, so, oe;
    int cnt, a, eff;
    logic [7:0] w, eb;
    rd = ins[15];
    cnt = int'(ins[14:13]);
    strm = (cnt == 3);
    oor = ins[12:5] != 8'h00;
    a = int'(ins[4:0]);
    eff = strm ? nb : (nb < cnt + 1 ? nb : cnt + 1);
    bus.csn = 1'b0;
    wait_clk(4);
    for (int i = 15; i >= 0; i--) begin
      setup(ins[i], so, oe);
      chk("instr_sdo_oe", 32'(oe), 0);
      pulse();
    end
    for (int k = 0; k < nb; k++) begin
      int ma;
      ma = (a + k) % DEPTH;
      w = wbuf[k];
      eb = oor ? 8'h00 : mem[ma];
      for (int j = 7; j >= 0; j--) begin
        setup(rd ? 1'($urandom) : w[j], so, oe);
        if (rd) begin
          chk("rd_sdo_oe", 32'(oe), 32'(k < eff));
          if (k < eff) begin
            chk("rd_sdo", 32'(so), 32'(eb[j]));
            rbuf[k][j] = so;
          end
        end else chk("wr_sdo_oe", 32'(oe), 0);
        if (!rd && j == 0 && k < eff && !oor) begin
          mem[ma] = w;
          expq.push_back({5'(ma), w});
        end
        pulse();
      end
    end
    for (int j = 0; j < ab; j++) begin
      setup(1'($urandom), so, oe);
      pulse();
    end
    wait_clk(6);
    if (ab == 0) chk("end_sdo_oe", 32'(bus.sdo_oe), 32'(rd && (strm || nb < cnt + 1)));
    chk("end_busy", 32'(bus.busy), 1);
    bus.csn = 1'b1;
    wait_clk(6);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_sdo_oe", 32'(bus.sdo_oe), 0);
    chk("idle_sdo", 32'(bus.sdo), 0);
    chk("wr_queue_drained", 32'(expq.size()), 0);
  endtask

  always @(posedge clk) begin
    logic [12:0] e;
    #2;
    if (rst_n) begin
      if (bus.wr_strobe) begin
        if (expq.size() == 0) chk("unexpected_wr_strobe", 1, 0);
        else begin
          e = expq.pop_front();
          chk("wr_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'(e));
        end
      end
      if (!bus.busy) chk("reg_data", 32'(bus.reg_data), 32'(mem[bus.reg_addr]));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic so, oe;
    logic [15:0] ins;
    bus.sclk = 1'b0;
    bus.sdi = 1'b0;
    bus.csn = 1'b1;
    bus.reg_addr = '0;
    rst_n = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    wait_clk(3);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_sdo", 32'(bus.sdo), 0);
    chk("rst_sdo_oe", 32'(bus.sdo_oe), 0);
    chk("rst_wr_strobe", 32'(bus.wr_strobe), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    rst_n = 1'b1;
    wait_clk(4);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    xfer(16'h2003, 2, 0);
    peek(3, d); chk("lit_reg3", 32'(d), 32'hA5);
    peek(4, d); chk("lit_reg4", 32'(d), 32'h3C);
    xfer(16'hA003, 2, 0);
    chk("lit_rd_byte0", 32'(rbuf[0]), 32'hA5);
    chk("lit_rd_byte1", 32'(rbuf[1]), 32'h3C);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    xfer(16'h601E, 4, 0);
    peek(30, d); chk("lit_wrap_1e", 32'(d), 32'h11);
    peek(31, d); chk("lit_wrap_1f", 32'(d), 32'h22);
    peek(0, d); chk("lit_wrap_00", 32'(d), 32'h33);
    peek(1, d); chk("lit_wrap_01", 32'(d), 32'h44);
    wbuf[0] = 8'hFF;
    xfer(16'h0040, 1, 0);
    peek(0, d); chk("lit_oor_no_write", 32'(d), 32'h33);
    xfer(16'h8040, 1, 0);
    chk("lit_oor_read", 32'(rbuf[0]), 32'h00);
    wbuf[0] = 8'h77;
    xfer(16'h0005, 1, 0);
    wbuf[0] = 8'h99;
    xfer(16'h0005, 0, 5);
    peek(5, d); chk("lit_abort_keeps", 32'(d), 32'h77);
    wbuf[0] = 8'h5C;
    xfer(16'h0005, 1, 0);
    peek(5, d); chk("lit_after_abort", 32'(d), 32'h5C);
    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    xfer(16'h0008, 2, 0);
    peek(8, d); chk("lit_done_byte", 32'(d), 32'h12);
    peek(9, d); chk("lit_done_ignored", 32'(d), 32'h00);
    for (int t = 0; t < 40; t++) begin
      logic [12:0] ad;
      int nb, ab;
      ad = 13'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ad[12:5] = 8'($urandom_range(1, 255));
      ins = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ad};
      nb = $urandom_range(1, 4);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      foreach (wbuf[i]) wbuf[i] = 8'($urandom);
      bus.reg_addr = AW'($urandom);
      xfer(ins, nb, ab);
    end
    bus.csn = 1'b0;
    wait_clk(4);
    ins = 16'hA003;
    for (int i = 15; i >= 0; i--) begin
      setup(ins[i], so, oe);
      pulse();
    end
    for (int i = 0; i < 3; i++) begin
      setup(1'b0, so, oe);
      pulse();
    end
    chk("pre_rst_sdo_oe", 32'(bus.sdo_oe), 1);
    rst_n = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    wait_clk(2);
    chk("mid_rst_sdo", 32'(bus.sdo), 0);
    chk("mid_rst_sdo_oe", 32'(bus.sdo_oe), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    ins = 16'h0007;
    for (int i = 15; i >= 0; i--) begin
      setup(ins[i], so, oe);
      pulse();
    end
    chk("ignored_busy_mid", 32'(bus.busy), 0);
    for (int j = 7; j >= 0; j--) begin
      setup(j[0], so, oe);
      pulse();
    end
    wait_clk(6);
    chk("ignored_busy_end", 32'(bus.busy), 0);
    bus.csn = 1'b1;
    wait_clk(6);
    for (int i = 0; i < DEPTH; i++) begin
      peek(i, d);
      chk("post_rst_zero", 32'(d), 0);
    end
    wbuf[0] = 8'hC3;
    xfer(16'h0007, 1, 0);
    peek(7, d); chk("lit_post_rst_write", 32'(d), 32'hC3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fadc_spi_responder.md
Name: fadc_spi_responder

Overview:
- SPI slave that emulates the FADC configuration port so the existing SPI master can be exercised in simulation and hardware loopback without an ADC fitted.
- Oversamples SCLK/SDI/CSN on one system clock and decodes a 16-bit instruction followed by data bytes.
- Holds a byte-wide register file and exposes a write-observe strobe plus a local read port for the bench and for debug LEDs.

Parameters:
ADDR_WIDTH, 5, register file depth is 2^ADDR_WIDTH bytes (32 by default).
SYNC_STAGES, 2, synchroniser flops on SCLK, SDI and CSN; minimum value 2.

Ports:
CLK  input  1  system clock; must be at least 4x SCLK frequency.
RST_N  input  1  synchronous reset, active-low.
SCLK  input  1  SPI clock from the master, asynchronous to CLK.
SDI  input  1  slave data in; sampled on SCLK rising edge.
CSN  input  1  chip select, active-low; high aborts or ends a transaction.
SDO  output  1  slave data out; changes on SCLK falling edge.
SDO_OE  output  1  high while a read data phase is driving SDO.
REG_ADDR  input  ADDR_WIDTH  local read address.
REG_DATA  output  8  register file content at REG_ADDR; combinational read.
WR_STROBE  output  1  one-CLK pulse when a byte commits to the register file.
WR_ADDR  output  ADDR_WIDTH  address of the committed byte; valid with WR_STROBE.
WR_DATA  output  8  value of the committed byte; valid with WR_STROBE.
BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (RST_N low at a CLK edge):
- All register file bytes go to 0x00; FSM goes to IDLE.
- SDO=0, SDO_OE=0, WR_STROBE=0, WR_ADDR=0, WR_DATA=0, BUSY=0; synchroniser flops go to SCLK=0, CSN=1.
- Reset applied mid-transaction discards the transaction. After reset the block waits for CSN to be high for at least one synchronised sample before it accepts a new falling edge of CSN.

Edge detection:
- rise = synchronised SCLK was 0 and is now 1; fall = synchronised SCLK was 1 and is now 0.
- Each detected event acts SYNC_STAGES+1 CLK cycles after the pin transition.

Instruction word (16 bits, MSB first):
- bit15: 1=read, 0=write.
- bits14:13: byte count minus 1. Value 3 means streaming: continue until CSN goes high.
- bits12:0: start address. Only the low ADDR_WIDTH bits are used for indexing. Any nonzero bit at or above ADDR_WIDTH marks the access as out-of-range.

FSM states:
- IDLE: CSN falling -> INSTR, bit counter cleared, BUSY=1.
- INSTR: shift SDI in on each rise. After the 16th rise -> WDATA or RDATA, with the byte counter and address loaded from the instruction.
- WDATA: shift SDI in on each rise. On the 8th rise, commit the byte in the next CLK:
  - register[addr] <= byte, WR_STROBE=1 for exactly one cycle, WR_ADDR/WR_DATA set.
  - Out-of-range address: write discarded, no WR_STROBE.
  - Then addr+1 and count-1. Count reaching 0 (non-streaming) -> DONE.
- RDATA: SDO_OE=1.
  - On the first fall after entering, drive the MSB of register[addr]; out-of-range addresses read 0x00.
  - Drive each subsequent bit on each following fall.
  - After the 8th bit has been sampled (8th rise), addr+1 and count-1. Count reaching 0 -> DONE with SDO_OE=0.
- DONE: ignore SCLK until CSN is high.
- Any state: CSN high -> IDLE in the same cycle the high level is seen. Any partial byte is discarded, SDO_OE=0, SDO=0, BUSY=0.

Address and width rules:
- Address increment wraps within ADDR_WIDTH bits (e.g. 0x1F -> 0x00 for the default).
- The out-of-range flag is evaluated once per transaction from the instruction and is not affected by wrap.
- Extra SCLK edges in DONE have no effect.

Simultaneous events:
- A local REG_ADDR read of a byte being committed returns the old value in the commit cycle and the new value from the next cycle.
- CSN high and the 8th rise detected in the same CLK cycle: abort wins, nothing is committed.

Test Plan:
- Reset, then write instr 0x2003 + data 0xA5,0x3C (2 bytes from addr 3) -> WR_STROBE pulses at addr 3 with 0xA5 and addr 4 with 0x3C; REG_DATA@3=0xA5, @4=0x3C.
- Read instr 0xA003 after the previous write -> SDO shifts 0xA5 then 0x3C MSB-first; SDO_OE high only during the 16 data bits; BUSY drops after CSN rises.
- Streaming write instr 0x601E + 4 bytes 0x11,0x22,0x33,0x44 -> addresses 0x1E,0x1F,0x00,0x01 written in that order (wrap verified).
- Write instr 0x0040 (addr 64, out of range) + 0xFF -> no WR_STROBE, register file unchanged; read of addr 64 returns 0x00 on SDO.
- Write to addr 5 with CSN raised after 5 data bits -> no commit, FSM in IDLE, REG_DATA@5 keeps its old value; next full transaction works.
- Assert RST_N low during the RDATA phase -> SDO=0, SDO_OE=0, all registers read 0x00; a transaction started before CSN has been seen high is ignored.
